// File: rtl/fb_pkg.sv
// Shared types and bank-rotation helpers for the triple-buffered frame store.
package fb_pkg;

    typedef logic [1:0] bank_idx_t;

    localparam bank_idx_t BANK_WR0   = 2'd0;
    localparam bank_idx_t BANK_PEND0 = 2'd1;
    localparam bank_idx_t BANK_RD0   = 2'd2;

    // The three roles always hold a permutation of {0,1,2}.
    typedef struct packed {
        bank_idx_t wr;
        bank_idx_t pend;
        bank_idx_t rd;
    } bank_set_t;

    localparam bank_set_t BANKS_RESET = '{wr: BANK_WR0, pend: BANK_PEND0, rd: BANK_RD0};

    typedef enum logic {
        PEND_EMPTY = 1'b0,
        PEND_FULL  = 1'b1
    } pend_state_t;

    // Writer finished a frame: it becomes pending, the old pending bank is reused.
    function automatic bank_set_t rotate_commit(input bank_set_t b);
        bank_set_t n;
        n      = b;
        n.wr   = b.pend;
        n.pend = b.wr;
        return n;
    endfunction

    // Reader at frame boundary takes the pending frame.
    function automatic bank_set_t rotate_swap(input bank_set_t b);
        bank_set_t n;
        n      = b;
        n.rd   = b.pend;
        n.pend = b.rd;
        return n;
    endfunction

    // Both at once: the just-finished frame goes straight to the reader.
    function automatic bank_set_t rotate_commit_swap(input bank_set_t b);
        bank_set_t n;
        n    = b;
        n.rd = b.wr;
        n.wr = b.rd;
        return n;
    endfunction

endpackage

// File: rtl/frame_buffer_rotator_if.sv
// Writer/scanner bus of the frame buffer rotator.
interface frame_buffer_rotator_if #(
    parameter int DATA_W = 32,
    parameter int PIX_W  = 24,
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
);
    import fb_pkg::*;

    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic [DATA_W/8-1:0]   wr_be;
    logic                  wr_commit;
    logic                  rd_en;
    logic [ADDR_W-2:0]     rd_addr;
    logic                  rd_swap;
    logic [PIX_W-1:0]      rd_data_top;
    logic [PIX_W-1:0]      rd_data_bot;
    logic                  rd_valid;
    logic                  swap_ack;
    logic                  frame_pending;
    bank_idx_t             wr_bank;
    bank_idx_t             rd_bank;
    logic [CNT_W-1:0]      frame_cnt;
    logic [CNT_W-1:0]      drop_cnt;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, wr_commit, rd_en, rd_addr, rd_swap,
        input  rd_data_top, rd_data_bot, rd_valid, swap_ack, frame_pending,
               wr_bank, rd_bank, frame_cnt, drop_cnt
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, wr_commit, rd_en, rd_addr, rd_swap,
        output rd_data_top, rd_data_bot, rd_valid, swap_ack, frame_pending,
               wr_bank, rd_bank, frame_cnt, drop_cnt
    );

endinterface

// File: rtl/be_ram_bank.sv
// One frame bank: byte-enabled write port, two registered read ports at {0,addr}/{1,addr}.
module be_ram_bank #(
    parameter int                 DATA_W     = 32,
    parameter int                 PIX_W      = 24,
    parameter int                 ADDR_W     = 12,
    parameter logic [DATA_W-1:0]  FILL_VALUE = '1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                we,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd_en,
    input  logic [ADDR_W-2:0]   rd_addr,
    output logic [PIX_W-1:0]    rd_data_top,
    output logic [PIX_W-1:0]    rd_data_bot
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    // NOTE: the array is never reset -- a reset port would stop it mapping to block RAM;
    // its power-up content comes from the declaration initialiser instead.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: FILL_VALUE};

    // Byte-lane write; lanes with a clear enable keep their old content.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (we && wr_be[i]) begin
                mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
    end

    // Registered row-pair read; output holds while rd_en is low.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_data_top <= '0;
            rd_data_bot <= '0;
        end else if (rd_en) begin
            rd_data_top <= mem[{1'b0, rd_addr}][PIX_W-1:0];
            rd_data_bot <= mem[{1'b1, rd_addr}][PIX_W-1:0];
        end
    end

endmodule

// File: rtl/frame_buffer_rotator.sv
// Triple-buffered frame store with internal write/pending/read bank rotation.
module frame_buffer_rotator
    import fb_pkg::*;
#(
    parameter int                 DATA_W     = 32,
    parameter int                 PIX_W      = 24,
    parameter int                 ADDR_W     = 12,
    parameter int                 CNT_W      = 16,
    parameter logic [DATA_W-1:0]  FILL_VALUE = '1
) (
    input  logic                   clk,
    input  logic                   resetn,
    frame_buffer_rotator_if.slave  bus
);
    bank_set_t        banks;
    pend_state_t      pend_state;
    bank_idx_t        rd_sel;
    logic             swap_ack;
    logic             rd_valid;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] drop_cnt;
    logic [PIX_W-1:0] bank_top [3];
    logic [PIX_W-1:0] bank_bot [3];

    for (genvar g = 0; g < 3; g++) begin : g_bank
        be_ram_bank #(
            .DATA_W     (DATA_W),
            .PIX_W      (PIX_W),
            .ADDR_W     (ADDR_W),
            .FILL_VALUE (FILL_VALUE)
        ) u_bank (
            .clk         (clk),
            .resetn      (resetn),
            .we          (bus.wr_en && (banks.wr == bank_idx_t'(g))),
            .wr_addr     (bus.wr_addr),
            .wr_data     (bus.wr_data),
            .wr_be       (bus.wr_be),
            .rd_en       (bus.rd_en),
            .rd_addr     (bus.rd_addr),
            .rd_data_top (bank_top[g]),
            .rd_data_bot (bank_bot[g])
        );
    end

    // Bank rotation, read-side bookkeeping and frame/drop counters.
    // NOTE: all state here uses non-blocking assignments so every branch sees the
    // pre-edge values of banks/pend_state, independent of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            banks      <= BANKS_RESET;
            pend_state <= PEND_EMPTY;
            rd_sel     <= BANK_RD0;
            swap_ack   <= 1'b0;
            rd_valid   <= 1'b0;
            frame_cnt  <= '0;
            drop_cnt   <= '0;
        end else begin
            swap_ack <= 1'b0;
            rd_valid <= bus.rd_en;
            // The read in a swap cycle still comes from the old read bank.
            if (bus.rd_en) rd_sel <= banks.rd;

            if (bus.wr_commit) begin
                if (pend_state == PEND_FULL && drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + CNT_W'(1);
                end
                if (bus.rd_swap) begin
                    banks      <= rotate_commit_swap(banks);
                    pend_state <= PEND_EMPTY;
                    swap_ack   <= 1'b1;
                    frame_cnt  <= frame_cnt + CNT_W'(1);
                end else begin
                    banks      <= rotate_commit(banks);
                    pend_state <= PEND_FULL;
                end
            end else if (bus.rd_swap && pend_state == PEND_FULL) begin
                banks      <= rotate_swap(banks);
                pend_state <= PEND_EMPTY;
                swap_ack   <= 1'b1;
                frame_cnt  <= frame_cnt + CNT_W'(1);
            end
        end
    end

    // Select the bank that was displayed when the read was issued.
    // NOTE: the default assignments ahead of the case keep this purely combinational.
    always_comb begin
        bus.rd_data_top = '0;
        bus.rd_data_bot = '0;
        case (rd_sel)
            2'd0: begin bus.rd_data_top = bank_top[0]; bus.rd_data_bot = bank_bot[0]; end
            2'd1: begin bus.rd_data_top = bank_top[1]; bus.rd_data_bot = bank_bot[1]; end
            2'd2: begin bus.rd_data_top = bank_top[2]; bus.rd_data_bot = bank_bot[2]; end
            default: ;
        endcase
    end

    assign bus.rd_valid      = rd_valid;
    assign bus.swap_ack      = swap_ack;
    assign bus.frame_pending = (pend_state == PEND_FULL);
    assign bus.wr_bank       = banks.wr;
    assign bus.rd_bank       = banks.rd;
    assign bus.frame_cnt     = frame_cnt;
    assign bus.drop_cnt      = drop_cnt;

endmodule

// File: tb/tb_frame_buffer_rotator.sv
// Self-checking bench: register checks plus a read-data scoreboard.
module tb_frame_buffer_rotator;

    logic clk = 1'b0;
    logic resetn;
    int   total = 0;
    int   bad   = 0;

    logic [47:0] exp_q [$];

    always #5 clk = ~clk;

    frame_buffer_rotator_if bus_if ();

    frame_buffer_rotator dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard consumer: every valid read must match the oldest expectation.
    always @(negedge clk) begin
        if (resetn && bus_if.rd_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_valid", 32'd1, 32'd0);
            end else begin
                logic [47:0] e;
                e = exp_q.pop_front();
                check("rd_top", {8'h0, bus_if.rd_data_top}, {8'h0, e[47:24]});
                check("rd_bot", {8'h0, bus_if.rd_data_bot}, {8'h0, e[23:0]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [31:0] d,
                            input logic [3:0] be, input logic commit);
        bus_if.wr_en     = 1'b1;
        bus_if.wr_addr   = a;
        bus_if.wr_data   = d;
        bus_if.wr_be     = be;
        bus_if.wr_commit = commit;
        tick();
        bus_if.wr_en     = 1'b0;
        bus_if.wr_commit = 1'b0;
    endtask

    task automatic strobe(input logic commit, input logic swap);
        bus_if.wr_commit = commit;
        bus_if.rd_swap   = swap;
        tick();
        bus_if.wr_commit = 1'b0;
        bus_if.rd_swap   = 1'b0;
    endtask

    task automatic do_read(input logic [10:0] a, input logic [23:0] et, input logic [23:0] eb);
        bus_if.rd_en   = 1'b1;
        bus_if.rd_addr = a;
        exp_q.push_back({et, eb});
        tick();
        bus_if.rd_en = 1'b0;
        tick();
        check("rd_valid_drop", {31'd0, bus_if.rd_valid}, 32'd0);
    endtask

    initial begin
        resetn           = 1'b0;
        bus_if.wr_en     = 1'b0;
        bus_if.wr_addr   = '0;
        bus_if.wr_data   = '0;
        bus_if.wr_be     = '0;
        bus_if.wr_commit = 1'b0;
        bus_if.rd_en     = 1'b0;
        bus_if.rd_addr   = '0;
        bus_if.rd_swap   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_bank", {30'd0, bus_if.wr_bank}, 32'd0);
        check("rst_rd_bank", {30'd0, bus_if.rd_bank}, 32'd2);
        check("rst_pending", {31'd0, bus_if.frame_pending}, 32'd0);
        check("rst_rd_valid", {31'd0, bus_if.rd_valid}, 32'd0);
        check("rst_swap_ack", {31'd0, bus_if.swap_ack}, 32'd0);
        check("rst_rd_top", {8'h0, bus_if.rd_data_top}, 32'd0);
        check("rst_frame_cnt", {16'd0, bus_if.frame_cnt}, 32'd0);
        check("rst_drop_cnt", {16'd0, bus_if.drop_cnt}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // Fill value visible in the initial display bank.
        do_read(11'd0, 24'hFFFFFF, 24'hFFFFFF);

        // Full frame through bank 0; read in the swap cycle still hits old bank 2.
        do_write(12'd0, 32'h00A1B2C3, 4'hF, 1'b0);
        do_write(12'd2048, 32'h00A1B2C3, 4'hF, 1'b0);
        strobe(1'b1, 1'b0);
        check("c1_wr_bank", {30'd0, bus_if.wr_bank}, 32'd1);
        check("c1_pending", {31'd0, bus_if.frame_pending}, 32'd1);
        bus_if.rd_en   = 1'b1;
        bus_if.rd_addr = 11'd0;
        exp_q.push_back({24'hFFFFFF, 24'hFFFFFF});
        strobe(1'b0, 1'b1);
        bus_if.rd_en = 1'b0;
        check("s1_ack", {31'd0, bus_if.swap_ack}, 32'd1);
        check("s1_rd_bank", {30'd0, bus_if.rd_bank}, 32'd0);
        check("s1_frame_cnt", {16'd0, bus_if.frame_cnt}, 32'd1);
        check("s1_pending", {31'd0, bus_if.frame_pending}, 32'd0);
        tick();
        check("s1_ack_pulse", {31'd0, bus_if.swap_ack}, 32'd0);
        do_read(11'd0, 24'hA1B2C3, 24'hA1B2C3);

        // Partial byte write into bank 1 (fill 0xFFFFFFFF) -> 0xFF22FF44.
        do_write(12'd5, 32'h11223344, 4'b0101, 1'b0);
        strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b1);
        check("s2_rd_bank", {30'd0, bus_if.rd_bank}, 32'd1);
        check("s2_frame_cnt", {16'd0, bus_if.frame_cnt}, 32'd2);
        do_read(11'd5, 24'h22FF44, 24'hFFFFFF);

        // Swap with nothing pending is ignored.
        strobe(1'b0, 1'b1);
        check("s3_no_ack", {31'd0, bus_if.swap_ack}, 32'd0);
        check("s3_rd_bank", {30'd0, bus_if.rd_bank}, 32'd1);
        check("s3_frame_cnt", {16'd0, bus_if.frame_cnt}, 32'd2);

        // Three commits, no swap; last write shares its cycle with the commit.
        do_write(12'd7, 32'h000000AA, 4'hF, 1'b1);
        do_write(12'd7, 32'h000000BB, 4'hF, 1'b1);
        check("m_wr_bank", {30'd0, bus_if.wr_bank}, 32'd2);
        do_write(12'd7, 32'h000000CC, 4'hF, 1'b1);
        check("m_drop_cnt", {16'd0, bus_if.drop_cnt}, 32'd2);
        check("m_pending", {31'd0, bus_if.frame_pending}, 32'd1);
        strobe(1'b0, 1'b1);
        check("m_rd_bank", {30'd0, bus_if.rd_bank}, 32'd2);
        check("m_frame_cnt", {16'd0, bus_if.frame_cnt}, 32'd3);
        do_read(11'd7, 24'h0000CC, 24'hFFFFFF);

        // Commit+swap with pending clear: wr 0 -> rd, rd 2 -> wr.
        strobe(1'b1, 1'b1);
        check("cs1_rd_bank", {30'd0, bus_if.rd_bank}, 32'd0);
        check("cs1_wr_bank", {30'd0, bus_if.wr_bank}, 32'd2);
        check("cs1_pending", {31'd0, bus_if.frame_pending}, 32'd0);
        check("cs1_ack", {31'd0, bus_if.swap_ack}, 32'd1);
        check("cs1_drop_cnt", {16'd0, bus_if.drop_cnt}, 32'd2);
        check("cs1_frame_cnt", {16'd0, bus_if.frame_cnt}, 32'd4);
        do_read(11'd0, 24'hA1B2C3, 24'hA1B2C3);

        // Commit+swap with pending set drops the pending frame.
        strobe(1'b1, 1'b0);
        strobe(1'b1, 1'b1);
        check("cs2_rd_bank", {30'd0, bus_if.rd_bank}, 32'd1);
        check("cs2_wr_bank", {30'd0, bus_if.wr_bank}, 32'd0);
        check("cs2_drop_cnt", {16'd0, bus_if.drop_cnt}, 32'd3);
        check("cs2_frame_cnt", {16'd0, bus_if.frame_cnt}, 32'd5);
        do_read(11'd5, 24'h22FF44, 24'hFFFFFF);

        // Asynchronous reset mid-cycle; RAM survives it.
        #2;
        resetn = 1'b0;
        #1;
        check("ar_wr_bank", {30'd0, bus_if.wr_bank}, 32'd0);
        check("ar_rd_bank", {30'd0, bus_if.rd_bank}, 32'd2);
        check("ar_pending", {31'd0, bus_if.frame_pending}, 32'd0);
        check("ar_frame_cnt", {16'd0, bus_if.frame_cnt}, 32'd0);
        check("ar_drop_cnt", {16'd0, bus_if.drop_cnt}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        do_read(11'd7, 24'h0000CC, 24'hFFFFFF);

        tick();
        check("sb_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
